// File: rtl/dp_ram_pkg.sv
// Shared types and constants for the parameterised dual-port RAM.
package dp_ram_pkg;

    // Controller states: normal operation, or sweeping the array to zero.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } dp_state_t;

    // Read-during-write behaviour when read and write hit the same address.
    localparam int RDW_OLD = 0;  // return the word as it was before the write
    localparam int RDW_NEW = 1;  // return the old word with written lanes replaced

endpackage

// File: rtl/dp_ram_core.sv
// Storage array: one byte-enabled write port, one registered read port.
// The array itself carries no reset; only the read register does.
module dp_ram_core #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int BYTE_W     = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH/BYTE_W-1:0]   wr_be,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           rd_en,
    input  logic [ADDR_WIDTH-1:0]          rd_addr,
    output logic [DATA_WIDTH-1:0]          rd_data
);

    localparam int NB    = DATA_WIDTH / BYTE_W;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Lane-wise write: only lanes with their enable bit set are updated.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_en && wr_be[i]) begin
                mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Registered read; holds its value when no read is issued, so the
    // same-cycle write is never visible here (old-data behaviour).
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/param_dp_ram.sv
// Parameterised simple dual-port RAM with byte enables, selectable
// read-during-write behaviour, optional output register and a
// one-word-per-cycle zero-clear sequence.
//
// Strobe semantics: wr_en, rd_en and clr_req are single-cycle requests
// sampled on the rising clock edge. There is no ready signal; busy = 1
// acts as "not ready" and any request presented while busy is dropped.
// Each accepted read produces exactly one rd_valid pulse with its data.
module param_dp_ram
    import dp_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int BYTE_W     = 8,
    parameter int RDW_MODE   = RDW_OLD,
    parameter int OUT_REG    = 0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           clr_req,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH/BYTE_W-1:0]   wr_be,
    input  logic [DATA_WIDTH-1:0]          d_in,
    input  logic                           rd_en,
    input  logic [ADDR_WIDTH-1:0]          rd_addr,
    output logic [DATA_WIDTH-1:0]          d_out,
    output logic                           rd_valid,
    output logic                           busy
);

    localparam int NB = DATA_WIDTH / BYTE_W;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    dp_state_t             state;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  busy_q;

    logic                  wr_acc;
    logic                  rd_acc;
    logic                  core_we;
    logic [ADDR_WIDTH-1:0] core_waddr;
    logic [NB-1:0]         core_be;
    logic [DATA_WIDTH-1:0] core_wdata;
    logic [DATA_WIDTH-1:0] core_q;

    logic                  v1;
    logic                  byp_hit;
    logic [NB-1:0]         byp_be;
    logic [DATA_WIDTH-1:0] byp_data;
    logic [DATA_WIDTH-1:0] rd_word;

    assign busy   = busy_q;
    assign wr_acc = wr_en && !busy_q && !reset;
    assign rd_acc = rd_en && !busy_q && !reset;

    // Clear controller: reset or a clr_req in IDLE sweeps every address once.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy_q   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        state    <= IDLE;
                        clr_addr <= '0;
                        busy_q   <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    state  <= CLEAR;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end

    // During a clear the write port belongs to the sweeper, so user writes
    // can never land in the array while busy.
    assign core_we    = busy_q ? 1'b1     : wr_acc;
    assign core_waddr = busy_q ? clr_addr : wr_addr;
    assign core_be    = busy_q ? '1       : wr_be;
    assign core_wdata = busy_q ? '0       : d_in;

    dp_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYTE_W     (BYTE_W)
    ) u_core (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (core_we),
        .wr_addr (core_waddr),
        .wr_be   (core_be),
        .wr_data (core_wdata),
        .rd_en   (rd_acc),
        .rd_addr (rd_addr),
        .rd_data (core_q)
    );

    // First read stage: valid flag plus the same-cycle write captured for
    // new-data forwarding; held between reads so d_out stays stable.
    always_ff @(posedge clock) begin
        if (reset) begin
            v1       <= 1'b0;
            byp_hit  <= 1'b0;
            byp_be   <= '0;
            byp_data <= '0;
        end else begin
            v1 <= rd_acc;
            if (rd_acc) begin
                byp_hit  <= (RDW_MODE == RDW_NEW) && wr_acc && (wr_addr == rd_addr);
                byp_be   <= wr_be;
                byp_data <= d_in;
            end
        end
    end

    // Overlay the forwarded write lanes onto the stored word when needed.
    always_comb begin
        rd_word = core_q;
        if (byp_hit) begin
            for (int i = 0; i < NB; i++) begin
                if (byp_be[i]) begin
                    rd_word[i*BYTE_W +: BYTE_W] = byp_data[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  v2;
            logic [DATA_WIDTH-1:0] d2;

            // Optional output stage: adds one cycle, keeps data/valid aligned.
            always_ff @(posedge clock) begin
                if (reset) begin
                    v2 <= 1'b0;
                    d2 <= '0;
                end else begin
                    v2 <= v1;
                    if (v1) begin
                        d2 <= rd_word;
                    end
                end
            end

            assign d_out    = d2;
            assign rd_valid = v2;
        end else begin : g_no_out_reg
            assign d_out    = rd_word;
            assign rd_valid = v1;
        end
    endgenerate

endmodule

// File: tb/tb_param_dp_ram.sv
// Bench for param_dp_ram: four instances covering both read-during-write
// modes with and without the output register, all driven by the same
// stimulus and checked every cycle against a word-level memory model.
module tb_param_dp_ram;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int NB    = 2;
    localparam int DEPTH = 16;
    localparam int NI    = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          clr_req;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [NB-1:0] wr_be;
    logic [DW-1:0] d_in;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    logic [DW-1:0] d_out    [NI];
    logic          rd_valid [NI];
    logic          busy     [NI];

    // Clock generation.
    always #5 clock = ~clock;

    // Instance g: RDW_MODE = g % 2, OUT_REG = g / 2.
    for (genvar g = 0; g < NI; g++) begin : g_dut
        param_dp_ram #(
            .DATA_WIDTH (DW),
            .ADDR_WIDTH (AW),
            .BYTE_W     (8),
            .RDW_MODE   (g % 2),
            .OUT_REG    (g / 2)
        ) dut (
            .clock    (clock),
            .reset    (reset),
            .clr_req  (clr_req),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_be    (wr_be),
            .d_in     (d_in),
            .rd_en    (rd_en),
            .rd_addr  (rd_addr),
            .d_out    (d_out[g]),
            .rd_valid (rd_valid[g]),
            .busy     (busy[g])
        );
    end

    // Reference model state.
    logic [DW-1:0] mem_m [DEPTH];
    int            busy_left;
    int            cyc;
    logic [DW-1:0] last_out [NI];

    // Scoreboard: expected read results with owning instance and due cycle.
    logic [DW-1:0] exp_q    [$];
    int            exp_inst [$];
    int            exp_due  [$];

    int checks;
    int errors;

    function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] base,
                                                 input logic [DW-1:0] nd,
                                                 input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = base;
        for (int l = 0; l < NB; l++) begin
            if (be[l]) r[l*8 +: 8] = nd[l*8 +: 8];
        end
        return r;
    endfunction

    task automatic set_idle();
        reset   = 1'b0;
        clr_req = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_addr = '0;
        rd_addr = '0;
        wr_be   = '0;
        d_in    = '0;
    endtask

    task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [NB-1:0] be);
        wr_en   = 1'b1;
        wr_addr = a;
        d_in    = d;
        wr_be   = be;
    endtask

    task automatic drive_read(input logic [AW-1:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
    endtask

    // One clock cycle: update the model from the inputs presented, take the
    // edge, compare every instance, then return the inputs to idle.
    task automatic tick(input string tag);
        logic          was_reset;
        logic [DW-1:0] old_w;
        logic [DW-1:0] new_w;
        logic          found;
        logic [DW-1:0] exp_d;
        logic          exp_busy;

        was_reset = reset;
        if (reset) begin
            exp_q.delete();
            exp_inst.delete();
            exp_due.delete();
            busy_left = DEPTH;
        end else if (busy_left > 0) begin
            busy_left--;
        end else begin
            if (rd_en) begin
                old_w = mem_m[rd_addr];
                new_w = (wr_en && wr_addr == rd_addr) ? lane_merge(old_w, d_in, wr_be) : old_w;
                for (int g = 0; g < NI; g++) begin
                    exp_q.push_back((g % 2 == 1) ? new_w : old_w);
                    exp_inst.push_back(g);
                    exp_due.push_back(cyc + 1 + g / 2);
                end
            end
            if (wr_en) mem_m[wr_addr] = lane_merge(mem_m[wr_addr], d_in, wr_be);
            if (clr_req) begin
                for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
                busy_left = DEPTH;
            end
        end

        @(posedge clock);
        cyc++;
        #1;
        exp_busy = (busy_left > 0);
        for (int g = 0; g < NI; g++) begin
            if (was_reset) last_out[g] = '0;
            found = 1'b0;
            for (int k = 0; k < exp_q.size(); k++) begin
                if (exp_inst[k] == g && exp_due[k] == cyc) begin
                    found = 1'b1;
                    last_out[g] = exp_q[k];
                    exp_q.delete(k);
                    exp_inst.delete(k);
                    exp_due.delete(k);
                    break;
                end
            end
            exp_d = last_out[g];
            checks++;
            if (rd_valid[g] !== found) begin
                errors++;
                $display("FAIL %s inst%0d rd_valid cyc=%0d: got %b expected %b",
                         tag, g, cyc, rd_valid[g], found);
            end
            checks++;
            if (d_out[g] !== exp_d) begin
                errors++;
                $display("FAIL %s inst%0d d_out cyc=%0d: got %h expected %h",
                         tag, g, cyc, d_out[g], exp_d);
            end
            checks++;
            if (busy[g] !== exp_busy) begin
                errors++;
                $display("FAIL %s inst%0d busy cyc=%0d: got %b expected %b",
                         tag, g, cyc, busy[g], exp_busy);
            end
        end
        set_idle();
    endtask

    // Counts busy-high samples after a clear has started; bounded.
    task automatic count_busy(input string tag, input logic hold_rd, output int cnt,
                              output int valids);
        cnt    = busy[0] ? 1 : 0;
        valids = 0;
        for (int i = 0; i < 40 && busy[0] === 1'b1; i++) begin
            if (hold_rd) drive_read(AW'($urandom_range(0, DEPTH - 1)));
            tick(tag);
            if (busy[0] === 1'b1) cnt++;
            for (int g = 0; g < NI; g++) if (rd_valid[g] === 1'b1) valids++;
        end
    endtask

    task automatic test_reset();
        int cnt;
        int valids;
        reset = 1'b1;
        tick("reset");
        count_busy("reset_clear", 1'b0, cnt, valids);
        checks++;
        if (cnt != DEPTH) begin
            errors++;
            $display("FAIL reset_busy_len: got %0d cycles expected %0d", cnt, DEPTH);
        end
    endtask

    task automatic test_zero_reads();
        for (int a = 0; a < DEPTH; a++) begin
            drive_read(AW'(a));
            tick("zero_reads");
            checks++;
            if (rd_valid[0] !== 1'b1 || d_out[0] !== 16'h0000) begin
                errors++;
                $display("FAIL zero_read addr %0d: got valid=%b data=%h expected valid=1 data=0000",
                         a, rd_valid[0], d_out[0]);
            end
        end
        tick("zero_flush");
        tick("zero_flush");
    endtask

    task automatic test_byte_enable();
        drive_write(4'd3, 16'hABCD, 2'b01);
        tick("be_wr_lo");
        drive_read(4'd3);
        tick("be_rd_lo");
        checks++;
        if (d_out[0] !== 16'h00CD) begin
            errors++;
            $display("FAIL be_low_lane: got %h expected 00cd", d_out[0]);
        end
        tick("be_flush");
        drive_write(4'd3, 16'h1200, 2'b10);
        tick("be_wr_hi");
        drive_read(4'd3);
        tick("be_rd_hi");
        checks++;
        if (d_out[0] !== 16'h12CD) begin
            errors++;
            $display("FAIL be_high_lane: got %h expected 12cd", d_out[0]);
        end
        tick("be_flush");
        drive_write(4'd3, 16'hFFFF, 2'b00);
        tick("be_wr_none");
        drive_read(4'd3);
        tick("be_rd_none");
        checks++;
        if (d_out[0] !== 16'h12CD) begin
            errors++;
            $display("FAIL be_none: got %h expected 12cd", d_out[0]);
        end
        tick("be_flush");
    endtask

    task automatic test_rdw();
        drive_write(4'd5, 16'h1111, 2'b11);
        tick("rdw_init");
        drive_write(4'd5, 16'h2222, 2'b11);
        drive_read(4'd5);
        tick("rdw_same");
        checks++;
        if (d_out[0] !== 16'h1111 || d_out[1] !== 16'h2222) begin
            errors++;
            $display("FAIL rdw_same_noreg: got old=%h new=%h expected old=1111 new=2222",
                     d_out[0], d_out[1]);
        end
        tick("rdw_wait");
        checks++;
        if (d_out[2] !== 16'h1111 || d_out[3] !== 16'h2222) begin
            errors++;
            $display("FAIL rdw_same_outreg: got old=%h new=%h expected old=1111 new=2222",
                     d_out[2], d_out[3]);
        end
        drive_read(4'd5);
        tick("rdw_next");
        checks++;
        if (d_out[0] !== 16'h2222) begin
            errors++;
            $display("FAIL rdw_next_read: got %h expected 2222", d_out[0]);
        end
        tick("rdw_flush");
        // Different addresses in the same cycle stay independent.
        drive_write(4'd6, 16'h3333, 2'b11);
        drive_read(4'd5);
        tick("rdw_diff");
        checks++;
        if (d_out[1] !== 16'h2222) begin
            errors++;
            $display("FAIL rdw_diff_addr: got %h expected 2222", d_out[1]);
        end
        tick("rdw_flush");
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] wv [4];
        logic [5:0]    vp;
        int            k;
        for (int a = 0; a < 4; a++) begin
            wv[a] = DW'($urandom_range(1, 16'hFFFF));
            drive_write(AW'(a), wv[a], 2'b11);
            tick("b2b_fill");
        end
        k = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive_read(AW'(i));
            tick("b2b_read");
            vp[i] = rd_valid[2];
            if (rd_valid[2] === 1'b1 && k < 4) begin
                checks++;
                if (d_out[2] !== wv[k]) begin
                    errors++;
                    $display("FAIL b2b_order idx %0d: got %h expected %h", k, d_out[2], wv[k]);
                end
                k++;
            end
        end
        checks++;
        if (vp !== 6'b011110) begin
            errors++;
            $display("FAIL b2b_valid_pattern: got %b expected 011110", vp);
        end
    endtask

    task automatic test_clear_ignore();
        int cnt;
        int valids;
        for (int a = 0; a < DEPTH; a++) begin
            drive_write(AW'(a), DW'($urandom_range(1, 16'hFFFF)) | 16'h0001, 2'b11);
            tick("clr_fill");
        end
        clr_req = 1'b1;
        tick("clr_start");
        cnt = busy[0] ? 1 : 0;
        for (int i = 0; i < 40 && busy[0] === 1'b1; i++) begin
            drive_write(AW'($urandom_range(0, DEPTH - 1)), 16'hBEEF, 2'b11);
            drive_read(AW'($urandom_range(0, DEPTH - 1)));
            clr_req = 1'b1;
            tick("clr_busy");
            if (busy[0] === 1'b1) cnt++;
        end
        checks++;
        if (cnt != DEPTH) begin
            errors++;
            $display("FAIL clr_busy_len: got %0d cycles expected %0d", cnt, DEPTH);
        end
        for (int a = 0; a < DEPTH; a++) begin
            drive_read(AW'(a));
            tick("clr_check");
            checks++;
            if (d_out[0] !== 16'h0000) begin
                errors++;
                $display("FAIL clr_zero addr %0d: got %h expected 0000", a, d_out[0]);
            end
        end
        tick("clr_flush");
        tick("clr_flush");
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        int valids;
        // A read immediately followed by reset: the registered-output
        // instances must never deliver it.
        drive_write(4'd9, 16'h5A5A, 2'b11);
        tick("rst_fill");
        drive_read(4'd9);
        tick("rst_inflight_rd");
        reset = 1'b1;
        tick("rst_inflight");
        checks++;
        if (rd_valid[2] !== 1'b0 || rd_valid[3] !== 1'b0) begin
            errors++;
            $display("FAIL rst_inflight_drop: got %b%b expected 00", rd_valid[2], rd_valid[3]);
        end
        count_busy("rst_clear1", 1'b1, cnt, valids);
        clr_req = 1'b1;
        tick("rst_clr_start");
        for (int i = 0; i < 6; i++) begin
            drive_read(AW'(i));
            tick("rst_clr_run");
        end
        reset = 1'b1;
        drive_read(4'd1);
        tick("rst_mid");
        count_busy("rst_clear2", 1'b1, cnt, valids);
        checks++;
        if (cnt != DEPTH) begin
            errors++;
            $display("FAIL rst_mid_busy_len: got %0d cycles expected %0d", cnt, DEPTH);
        end
        checks++;
        if (valids != 0) begin
            errors++;
            $display("FAIL rst_mid_no_valid: got %0d pulses expected 0", valids);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] wa;
        for (int i = 0; i < 300; i++) begin
            wa = AW'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 1) == 1)
                drive_write(wa, DW'($urandom), NB'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) != 0)
                drive_read(($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1)));
            clr_req = ($urandom_range(0, 63) == 0);
            tick("random");
        end
        for (int i = 0; i < 20; i++) tick("random_drain");
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        busy_left = 0;
        for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
        for (int g = 0; g < NI; g++) last_out[g] = '0;
        set_idle();
        test_reset();
        test_zero_reads();
        test_byte_enable();
        test_rdw();
        test_back_to_back();
        test_clear_ignore();
        test_reset_mid_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_dp_ram.md
PARAM_DP_RAM -- requirements
Module: param_dp_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 16, word width in bits; SHALL be a multiple of BYTE_W.
REQ-002 Parameter ADDR_WIDTH, default 4, address width; depth DEPTH = 2**ADDR_WIDTH (derived, not overridable).
REQ-003 Parameter BYTE_W, default 8, byte-lane width; NB = DATA_WIDTH/BYTE_W lanes.
REQ-004 Parameter RDW_MODE, default 0, read-during-write same address: 0 = old data, 1 = new (merged) data.
REQ-005 Parameter OUT_REG, default 0, extra output pipeline stage: 0 = off, 1 = on.
REQ-006 Ports SHALL be: clock in 1 system clock; reset in 1 synchronous, active-high reset.
REQ-007 clr_req  in  1  pulse, requests a full-memory zero clear.
REQ-008 wr_en  in  1  write strobe; wr_addr  in  ADDR_WIDTH; wr_be  in  NB  byte-lane enables; d_in  in  DATA_WIDTH.
REQ-009 rd_en  in  1  read strobe; rd_addr  in  ADDR_WIDTH.
REQ-010 d_out  out  DATA_WIDTH  read data; rd_valid  out  1  d_out carries a new read result this cycle.
REQ-011 busy  out  1  clear sequence in progress.

Function
REQ-012 FSM states SHALL be IDLE and CLEAR; reset or clr_req in IDLE -> CLEAR with clr_addr = 0.
REQ-013 In CLEAR, one word per cycle SHALL be written to zero at clr_addr, with clr_addr incrementing; at clr_addr == DEPTH-1 the word is zeroed and the next state is IDLE.
REQ-014 A clear SHALL take exactly DEPTH cycles from the first CLEAR cycle; busy SHALL be 1 in every CLEAR cycle and 0 in IDLE.
REQ-015 While busy = 1, wr_en, rd_en and clr_req SHALL be ignored; no user write may corrupt the memory.
REQ-016 In IDLE, wr_en = 1 SHALL update only the lanes of mem[wr_addr] whose wr_be bit is 1; wr_be = 0 leaves the memory unchanged.
REQ-017 Read latency SHALL be 1 cycle (OUT_REG = 0) or 2 cycles (OUT_REG = 1) from rd_en sampled high to d_out valid; rd_valid SHALL be aligned with d_out.
REQ-018 rd_valid SHALL be a single-cycle pulse per accepted read; back-to-back reads SHALL yield one result per cycle.
REQ-019 d_out SHALL hold its last value when no read completes.
REQ-020 Same-address read and write in one cycle: RDW_MODE 0 returns the pre-write word; RDW_MODE 1 returns the old word with the enabled lanes replaced by d_in.
REQ-021 Different-address reads and writes in the same cycle SHALL be fully independent.
REQ-022 Addresses wrap naturally; all ADDR_WIDTH values are legal, with no out-of-range case.

Reset
REQ-023 On reset: d_out = 0, rd_valid = 0, the OUT_REG pipeline is cleared, state = CLEAR, clr_addr = 0, busy = 1 in the following cycle.
REQ-024 While reset is held, clr_addr SHALL remain 0; the clear runs DEPTH cycles after reset deasserts.
REQ-025 A reset asserted mid-clear SHALL restart the clear from address 0; in-flight reads SHALL be discarded with no rd_valid.

Structure
REQ-026 Package dp_ram_pkg SHALL hold the state typedef (IDLE, CLEAR) and the RDW_OLD/RDW_NEW mode constants.
REQ-027 Storage SHALL be sub-module dp_ram_core (byte-enable write port, registered read port, no reset on the array); the FSM, bypass and pipeline logic reside in param_dp_ram.

Verification
REQ-028 Defaults; reset 1 cycle then release -> busy high for exactly 16 cycles; every read afterwards returns 0x0000 with rd_valid one cycle after rd_en.
REQ-029 Write 0xABCD at addr 3 with wr_be = 2'b01, then read addr 3 -> 0x00CD; then write 0x1200 with wr_be = 2'b10, read -> 0x12CD.
REQ-030 Addr 5 = 0x1111; same-cycle write 0x2222 (be 2'b11) and read addr 5 -> RDW_MODE 0 gives 0x1111, RDW_MODE 1 gives 0x2222; a read the next cycle gives 0x2222.
REQ-031 OUT_REG = 1, reads of addr 0..3 on 4 consecutive cycles -> 4 consecutive rd_valid pulses starting 2 cycles later, with data in order.
REQ-032 clr_req after filling memory, wr_en asserted during busy -> all words read 0 after busy falls; the ignored write has no effect.
REQ-033 reset asserted at clear cycle 7 -> busy stays high and completes a fresh 16-cycle clear after release; no rd_valid during that period.
